// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM dump path (engine and sram_driver).
package sram_pkg;

    // Engine sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_LOW  = 3'd2,
        RD_HIGH = 3'd3,
        TX_REQ  = 3'd4,
        TX_ACK  = 3'd5,
        CSUM    = 3'd6,
        FINISH  = 3'd7
    } state_t;

    // Default for appending the trailing checksum byte.
    localparam int CSUM_EN = 1;

    // Byte that brings a modulo-256 running sum back to zero.
    function automatic logic [7:0] csum_complement(input logic [7:0] sum);
        return ~sum + 8'd1;
    endfunction

endpackage

// File: rtl/sram_dump_engine_if.sv
// Bus bundle between the dump engine, the sram_driver and the uart_tx.
interface sram_dump_engine_if #(
    parameter int ADDR_W = 13
);
    logic              ram_ready;
    logic [7:0]        ram_data_read;
    logic              ram_re;
    logic              ram_start;
    logic [ADDR_W-1:0] ram_address;
    logic              tx_ready;
    logic              tx_start;
    logic [7:0]        tx_data;

    modport master (
        input  ram_ready, ram_data_read, tx_ready,
        output ram_re, ram_start, ram_address, tx_start, tx_data
    );

    modport slave (
        output ram_ready, ram_data_read, tx_ready,
        input  ram_re, ram_start, ram_address, tx_start, tx_data
    );
endinterface

// File: rtl/sram_dump_engine_tx_byte_handshake.sv
// Launches one byte to the UART and detects its acceptance as a falling
// edge on tx_ready, which rides out the UART's two-cycle ready latency.
module tx_byte_handshake (
    input  logic       clk,
    input  logic       reset,
    input  logic       launch_en,
    input  logic       ack_en,
    input  logic [7:0] byte_in,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       launched,
    output logic       acked
);
    logic tx_ready_q;

    assign launched = launch_en & tx_ready;
    assign acked    = ack_en & tx_ready_q & ~tx_ready;

    // Strobe/data registers; tx_ready history for the edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            tx_ready_q <= 1'b0;
        end else begin
            tx_ready_q <= tx_ready;
            if (launched) begin
                tx_start <= 1'b1;
                tx_data  <= byte_in;
            end else if (acked) begin
                tx_start <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sram_dump_engine.sv
// Reads a block of SRAM byte by byte and streams it out of the UART,
// optionally followed by a checksum byte that zeroes the modulo-256 sum.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for go with the SRAM driver ready
// RD_REQ  | one-cycle ram_start (or straight to FINISH if nothing left)
// RD_LOW  | waiting for the driver to drop ram_ready
// RD_HIGH | waiting for ram_ready to return; data captured then
// TX_REQ  | waiting for tx_ready to launch the byte
// TX_ACK  | holding tx_start until tx_ready falls
// CSUM    | loading the checksum complement as the next byte
// FINISH  | done pulse, back to IDLE
module sram_dump_engine
    import sram_pkg::*;
#(
    parameter int ADDR_W        = 13,
    parameter int SEND_CHECKSUM = CSUM_EN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    sram_dump_engine_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic [7:0]        byte_q;
    logic              abort_pend;
    logic              in_csum;
    logic              launch_en, ack_en;
    logic              hs_launched, hs_acked;
    logic              hs_tx_start;
    logic [7:0]        hs_tx_data;
    logic              accept;

    assign accept          = (state == IDLE) && go && bus.ram_ready;
    assign busy            = (state != IDLE);
    assign done            = (state == FINISH);
    assign bus.ram_re      = busy;
    assign bus.ram_start   = (state == RD_REQ) && (remain_q != '0);
    assign bus.ram_address = addr_q;
    assign bus.tx_start    = hs_tx_start;
    assign bus.tx_data     = hs_tx_data;

    tx_byte_handshake u_tx (
        .clk      (clk),
        .reset    (reset),
        .launch_en(launch_en),
        .ack_en   (ack_en),
        .byte_in  (byte_q),
        .tx_ready (bus.tx_ready),
        .tx_start (hs_tx_start),
        .tx_data  (hs_tx_data),
        .launched (hs_launched),
        .acked    (hs_acked)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and handshake enables.
    always_comb begin
        state_nx  = state;
        launch_en = 1'b0;
        ack_en    = 1'b0;
        case (state)
            IDLE:    if (accept) state_nx = RD_REQ;
            RD_REQ:  state_nx = (remain_q == '0) ? FINISH : RD_LOW;
            RD_LOW:  if (!bus.ram_ready) state_nx = RD_HIGH;
            RD_HIGH: if (bus.ram_ready) state_nx = TX_REQ;
            TX_REQ: begin
                launch_en = 1'b1;
                if (hs_launched) state_nx = TX_ACK;
            end
            TX_ACK: begin
                ack_en = 1'b1;
                if (hs_acked) begin
                    if (in_csum || abort_pend || abort) state_nx = FINISH;
                    else if (remain_q == '0)
                        state_nx = (SEND_CHECKSUM != 0) ? CSUM : FINISH;
                    else state_nx = RD_REQ;
                end
            end
            CSUM:    state_nx = TX_REQ;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Address/count/byte datapath, abort latch and running checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            remain_q   <= '0;
            byte_q     <= 8'h00;
            checksum   <= 8'h00;
            abort_pend <= 1'b0;
            in_csum    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= start_addr;
                remain_q   <= length;
                checksum   <= 8'h00;
                abort_pend <= 1'b0;
                in_csum    <= 1'b0;
            end
            if (busy && abort) abort_pend <= 1'b1;
            if (state == RD_HIGH && bus.ram_ready) begin
                byte_q   <= bus.ram_data_read;
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
            end
            if (hs_acked) checksum <= checksum + hs_tx_data;
            if (state == CSUM) begin
                byte_q  <= csum_complement(checksum);
                in_csum <= 1'b1;
            end
        end
    end
endmodule
